wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Writer end of the register-file write port: owns WB_Dst/WB_Result/RFWr. Merges the in-order
//  WB pipe result with late multi-cycle (mul/div) results held in a small FIFO, registered, 1 write/cycle.
//  Flags ID reads of registers still queued so the hazard unit can stall ID.
// PARAMETERS
//  AUX_DEPTH     2  aux FIFO entries (>=1)
//  STARVE_LIMIT  4  consecutive blocked cycles before the FIFO head forces a pipe stall (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  pipe_valid    in   1   WB-stage result present (no ready; consumed unless pipe_stall=1)
//  pipe_dst      in   5   pipe destination register
//  pipe_result   in   32  pipe write data
//  pipe_stall    out  1   registered; 1 = pipe input not consumed this cycle, upstream holds
//  aux_valid     in   1   multi-cycle unit result valid
//  aux_ready     out  1   FIFO can accept (aux_valid&&aux_ready = transfer)
//  aux_dst       in   5   aux destination register
//  aux_result    in   32  aux write data
//  WB_Dst        out  5   RF write address (registered)
//  WB_Result     out  32  RF write data (registered)
//  RFWr          out  1   RF write enable (registered)
//  ID_rs, ID_rt  in   5   ID read addresses
//  ID_rs_pending out  1   ID_rs!=0 and matches a valid FIFO entry's dst
//  ID_rt_pending out  1   same for ID_rt
//  fifo_count    out  $clog2(AUX_DEPTH+1)  occupied FIFO entries
// BEHAVIOUR
//  Reset (async): RFWr=0, WB_Dst=0, WB_Result=0, pipe_stall=0, FIFO empty, state NORMAL, starve_cnt=0;
//   aux_ready=0 while rst=1 (combinational gate), pending outputs 0.
//  aux_ready = !rst && fifo_count<AUX_DEPTH; computed from pre-pop count (no same-cycle full pass-through).
//  Slot select per cycle, state NORMAL: pipe_valid > FIFO head > aux bypass (aux handshake with FIFO empty).
//   Winner appears on WB_* with RFWr=1 at next edge (latency 1). No winner: RFWr<=0, WB_Dst/WB_Result hold.
//  Accepted aux not taking the slot is pushed at the tail; simultaneous push+pop legal; order preserved FIFO.
//  dst==0 from any source: consumed/popped normally, RFWr<=0 for that slot.
//  starve_cnt: +1 each cycle FIFO non-empty and pipe wins; cleared on pop or when FIFO empty.
//  FSM NORMAL->STARVED when blocked with starve_cnt==STARVE_LIMIT-1; STARVED lasts exactly 1 cycle:
//   pipe_stall=1, FIFO head wins, pipe input ignored (held upstream), aux push still allowed; ->NORMAL, cnt=0.
//  Pending: combinational over valid FIFO entries only; the registered WB_* write is covered by RF bypass.
//  Cross-source same-dst ordering is the hazard unit's job (must stall on *_pending).
// CONFIGURATION
//  DEBUG_TRACE_EN defined: adds inputs pipe_pc[31:0], aux_pc[31:0]; FIFO entries carry pc; adds outputs
//   debug_wb_pc[31:0], debug_wb_rf_wen[3:0] (4'hF on RFWr, else 0), debug_wb_rf_wnum[4:0],
//   debug_wb_rf_wdata[31:0], registered aligned with RFWr, reset to 0.
//  Undefined: pc ports, pc storage and debug outputs absent; write behaviour identical.
// STRUCTURE
//  Shared package cpu_pkg: typedef wb_req_t {dst[4:0], result[31:0], pc[31:0] under DEBUG_TRACE_EN};
//   enum wb_arb_state_t {WB_NORMAL, WB_STARVED}.
//  Sub-module wb_fifo: parameterised circular FIFO of wb_req_t (push/pop/count/full/empty, entry view
//   for pending compare). Arbiter, FSM, output registers in top.
// TESTING
//  Reset mid-op: FIFO holds 2 entries, RFWr=1, assert rst -> RFWr=0, fifo_count=0 with no clock edge;
//   aux_ready=0 during rst, 1 first cycle after release.
//  Bypass: FIFO empty, pipe_valid=0, aux dst=5 data=0x1234 at t -> t+1 RFWr=1 WB_Dst=5 WB_Result=0x1234,
//   fifo_count stays 0.
//  Conflict: t pipe dst=3 data=0xA, aux dst=7 data=0xB -> t+1 writes r3, fifo_count=1, ID_rt=7 gives
//   ID_rt_pending=1; t+1 pipe idle -> t+2 writes r7=0xB, pending 0.
//  Starvation (LIMIT=4): one aux entry pushed at t, pipe_valid=1 forever -> pipe writes t+1..t+5,
//   pipe_stall=1 only in t+5, r(aux) written at t+6, pipe resumes t+7.
//  Full (DEPTH=2): pipe_valid=1 continuously, 3 aux requests -> 2 accepted, aux_ready=0, 3rd held stable
//   until a pop frees a slot.
//  $0: pipe dst=0 data=0xFFFF -> RFWr stays 0; with DEBUG_TRACE_EN debug_wb_rf_wen=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types for the write-back path. DEBUG_TRACE_EN adds a pc field to wb_req_t.
package cpu_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic [XLEN-1:0]  result;
`ifdef DEBUG_TRACE_EN
    logic [XLEN-1:0]  pc;
`endif
  } wb_req_t;

  typedef enum logic {
    WB_NORMAL  = 1'b0,
    WB_STARVED = 1'b1
  } wb_arb_state_t;

  // $0 is hard-wired zero: such requests are consumed but never written
  function automatic logic writes_rf(input wb_req_t req);
    return req.dst != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of write-back requests with a per-slot view for hazard compares.
// Entry width follows wb_req_t, so DEBUG_TRACE_EN also stores pc here.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  wb_req_t                      din_i,
  input  logic                         pop_i,
  output wb_req_t                      head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output wb_req_t [DEPTH-1:0]          entry_o,
  output logic    [DEPTH-1:0]          entry_vld_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  int               off;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // A physical slot is live when its distance from the read pointer is below the count
  always_comb begin
    off = 0;
    for (int i = 0; i < DEPTH; i++) begin
      off = (i >= int'(rd_ptr_q)) ? i - int'(rd_ptr_q) : i + DEPTH - int'(rd_ptr_q);
      entry_o[i]     = mem_q[i];
      entry_vld_o[i] = off < int'(count_q);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = count_q == CNT_W'(DEPTH);
  assign empty_o = count_q == '0;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port owner: merges in-order pipe results with late mul/div results.
// Define DEBUG_TRACE_EN for pc inputs and the debug_wb_* trace outputs.
module wb_write_arbiter
  import cpu_pkg::*;
#(
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pipe_valid,
  input  logic [4:0]                        pipe_dst,
  input  logic [31:0]                       pipe_result,
  output logic                              pipe_stall,
  input  logic                              aux_valid,
  output logic                              aux_ready,
  input  logic [4:0]                        aux_dst,
  input  logic [31:0]                       aux_result,
  output logic [4:0]                        WB_Dst,
  output logic [31:0]                       WB_Result,
  output logic                              RFWr,
  input  logic [4:0]                        ID_rs,
  input  logic [4:0]                        ID_rt,
  output logic                              ID_rs_pending,
  output logic                              ID_rt_pending,
`ifdef DEBUG_TRACE_EN
  input  logic [31:0]                       pipe_pc,
  input  logic [31:0]                       aux_pc,
  output logic [31:0]                       debug_wb_pc,
  output logic [3:0]                        debug_wb_rf_wen,
  output logic [4:0]                        debug_wb_rf_wnum,
  output logic [31:0]                       debug_wb_rf_wdata,
`endif
  output logic [$clog2(AUX_DEPTH+1)-1:0]    fifo_count
);

  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  wb_arb_state_t             state_q, state_d;
  logic [SCNT_W-1:0]         starve_cnt_q, starve_cnt_d;
  logic                      rfwr_q, pipe_stall_q;
  logic [4:0]                wb_dst_q;
  logic [31:0]               wb_result_q;

  wb_req_t                   pipe_req, aux_req, fifo_head, win_req;
  wb_req_t [AUX_DEPTH-1:0]   fifo_entry;
  logic    [AUX_DEPTH-1:0]   fifo_entry_vld;
  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                      aux_fire, blocked, win_vld, rf_we;
  logic                      rs_hit, rt_hit;

`ifdef DEBUG_TRACE_EN
  logic [31:0]               wb_pc_q;
  assign pipe_req = '{dst: pipe_dst, result: pipe_result, pc: pipe_pc};
  assign aux_req  = '{dst: aux_dst,  result: aux_result,  pc: aux_pc};
`else
  assign pipe_req = '{dst: pipe_dst, result: pipe_result};
  assign aux_req  = '{dst: aux_dst,  result: aux_result};
`endif

  wb_fifo #(.DEPTH(AUX_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .din_i       (aux_req),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .entry_o     (fifo_entry),
    .entry_vld_o (fifo_entry_vld)
  );

  // Ready looks at the pre-pop occupancy, so a full FIFO never accepts in the cycle it drains
  assign aux_ready = !rst && !fifo_full;
  assign aux_fire  = aux_valid && aux_ready;
  assign blocked   = (state_q == WB_NORMAL) && pipe_valid && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WB_NORMAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_NORMAL:  if (blocked && starve_cnt_q == SCNT_W'(STARVE_LIMIT - 1)) state_d = WB_STARVED;
      WB_STARVED: state_d = WB_NORMAL;
    endcase
  end

  always_comb begin
    win_vld   = 1'b0;
    win_req   = pipe_req;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      WB_STARVED: begin
        win_vld   = !fifo_empty;
        win_req   = fifo_head;
        fifo_pop  = !fifo_empty;
        fifo_push = aux_fire;
      end
      WB_NORMAL: begin
        if (pipe_valid) begin
          win_vld   = 1'b1;
          fifo_push = aux_fire;
        end else if (!fifo_empty) begin
          win_vld   = 1'b1;
          win_req   = fifo_head;
          fifo_pop  = 1'b1;
          fifo_push = aux_fire;
        end else if (aux_fire) begin
          win_vld   = 1'b1;
          win_req   = aux_req;
        end
      end
    endcase

    if (state_d == WB_STARVED || fifo_pop || fifo_empty) starve_cnt_d = '0;
    else if (blocked)                                     starve_cnt_d = starve_cnt_q + 1'b1;
    else                                                  starve_cnt_d = starve_cnt_q;
  end

  assign rf_we = win_vld && writes_rf(win_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfwr_q       <= 1'b0;
      wb_dst_q     <= '0;
      wb_result_q  <= '0;
      pipe_stall_q <= 1'b0;
      starve_cnt_q <= '0;
`ifdef DEBUG_TRACE_EN
      wb_pc_q      <= '0;
`endif
    end else begin
      rfwr_q       <= rf_we;
      pipe_stall_q <= state_d == WB_STARVED;
      starve_cnt_q <= starve_cnt_d;
      if (rf_we) begin
        wb_dst_q    <= win_req.dst;
        wb_result_q <= win_req.result;
`ifdef DEBUG_TRACE_EN
        wb_pc_q     <= win_req.pc;
`endif
      end
    end
  end

  // The registered WB write is covered by RF bypass; only queued entries count as pending
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < AUX_DEPTH; i++) begin
      if (fifo_entry_vld[i] && fifo_entry[i].dst == ID_rs) rs_hit = 1'b1;
      if (fifo_entry_vld[i] && fifo_entry[i].dst == ID_rt) rt_hit = 1'b1;
    end
  end

  assign ID_rs_pending = (ID_rs != '0) && rs_hit;
  assign ID_rt_pending = (ID_rt != '0) && rt_hit;
  assign RFWr          = rfwr_q;
  assign WB_Dst        = wb_dst_q;
  assign WB_Result     = wb_result_q;
  assign pipe_stall    = pipe_stall_q;

`ifdef DEBUG_TRACE_EN
  assign debug_wb_pc       = wb_pc_q;
  assign debug_wb_rf_wen   = {4{rfwr_q}};
  assign debug_wb_rf_wnum  = wb_dst_q;
  assign debug_wb_rf_wdata = wb_result_q;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_wb_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, aux_valid;
  logic [4:0]  pipe_dst, aux_dst, ID_rs, ID_rt;
  logic [31:0] pipe_result, aux_result;
  wire         pipe_stall, aux_ready, RFWr, ID_rs_pending, ID_rt_pending;
  wire  [4:0]  WB_Dst;
  wire  [31:0] WB_Result;
  wire  [1:0]  fifo_count;
`ifdef DEBUG_TRACE_EN
  logic [31:0] pipe_pc = 32'h0, aux_pc = 32'h0;
  wire  [31:0] debug_wb_pc, debug_wb_rf_wdata;
  wire  [3:0]  debug_wb_rf_wen;
  wire  [4:0]  debug_wb_rf_wnum;
`endif

  int checks   = 0;
  int failures = 0;

  wb_write_arbiter #(.AUX_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_valid    (pipe_valid),
    .pipe_dst      (pipe_dst),
    .pipe_result   (pipe_result),
    .pipe_stall    (pipe_stall),
    .aux_valid     (aux_valid),
    .aux_ready     (aux_ready),
    .aux_dst       (aux_dst),
    .aux_result    (aux_result),
    .WB_Dst        (WB_Dst),
    .WB_Result     (WB_Result),
    .RFWr          (RFWr),
    .ID_rs         (ID_rs),
    .ID_rt         (ID_rt),
    .ID_rs_pending (ID_rs_pending),
    .ID_rt_pending (ID_rt_pending),
`ifdef DEBUG_TRACE_EN
    .pipe_pc           (pipe_pc),
    .aux_pc            (aux_pc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
`endif
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  // Reference model: a queue of pending late results plus a one-shot "starved" flag
  typedef struct {
    logic [4:0]  dst;
    logic [31:0] res;
  } ent_t;

  ent_t        mq[$];
  bit          m_starved, m_aux_taken;
  int          m_cnt;
  logic        m_rfwr, m_stall;
  logic [4:0]  m_dst;
  logic [31:0] m_res;

  function automatic bit m_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic bit m_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].dst == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_starved = 0; m_aux_taken = 0; m_cnt = 0;
    m_rfwr = 0; m_stall = 0; m_dst = '0; m_res = '0;
  endtask

  task automatic model_step();
    ent_t win;
    bit have = 0, blocked = 0, bypass = 0, fire;
    fire = aux_valid && m_ready();
    m_aux_taken = fire;
    if (m_starved) begin
      win = mq.pop_front(); have = 1;
    end else if (pipe_valid) begin
      win.dst = pipe_dst; win.res = pipe_result; have = 1;
      blocked = mq.size() > 0;
    end else if (mq.size() > 0) begin
      win = mq.pop_front(); have = 1;
    end else if (fire) begin
      win.dst = aux_dst; win.res = aux_result; have = 1; bypass = 1;
    end
    if (fire && !bypass) mq.push_back('{dst: aux_dst, res: aux_result});
    if (m_starved) begin
      m_starved = 0; m_cnt = 0;
    end else if (blocked) begin
      if (m_cnt == LIMIT - 1) begin m_starved = 1; m_cnt = 0; end
      else m_cnt++;
    end else begin
      m_cnt = 0;
    end
    m_stall = m_starved;
    m_rfwr  = have && (win.dst != 5'd0);
    if (m_rfwr) begin m_dst = win.dst; m_res = win.res; end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 0; pipe_dst = '0; pipe_result = '0;
    aux_valid  = 0; aux_dst  = '0; aux_result  = '0;
    ID_rs = '0; ID_rt = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (RFWr !== 1'b0) begin failures++; $display("FAIL reset_rfwr: got %0b want 0", RFWr); end
    checks++; if (WB_Dst !== 5'd0) begin failures++; $display("FAIL reset_dst: got %0d want 0", WB_Dst); end
    checks++; if (WB_Result !== 32'd0) begin failures++; $display("FAIL reset_result: got %0h want 0", WB_Result); end
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b want 0", pipe_stall); end
    checks++; if (fifo_count !== 2'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (aux_ready !== 1'b0) begin failures++; $display("FAIL reset_aux_ready: got %0b want 0", aux_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (aux_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %0b want 1", aux_ready); end
  endtask

  task automatic test_bypass();
    apply_reset();
    aux_valid = 1; aux_dst = 5'd5; aux_result = 32'h1234;
    tick();
    aux_valid = 0;
    checks++; if (RFWr !== 1'b1) begin failures++; $display("FAIL bypass_rfwr: got %0b want 1", RFWr); end
    checks++; if (WB_Dst !== 5'd5) begin failures++; $display("FAIL bypass_dst: got %0d want 5", WB_Dst); end
    checks++; if (WB_Result !== 32'h1234) begin failures++; $display("FAIL bypass_result: got %0h want 1234", WB_Result); end
    checks++; if (fifo_count !== 2'd0) begin failures++; $display("FAIL bypass_count: got %0d want 0", fifo_count); end
    tick();
    checks++; if (RFWr !== 1'b0) begin failures++; $display("FAIL bypass_idle_rfwr: got %0b want 0", RFWr); end
    checks++; if (WB_Dst !== 5'd5) begin failures++; $display("FAIL bypass_hold_dst: got %0d want 5", WB_Dst); end
  endtask

  task automatic test_conflict();
    apply_reset();
    ID_rs = 5'd3; ID_rt = 5'd7;
    pipe_valid = 1; pipe_dst = 5'd3; pipe_result = 32'hA;
    aux_valid  = 1; aux_dst  = 5'd7; aux_result  = 32'hB;
    tick();
    pipe_valid = 0; aux_valid = 0;
    checks++; if (RFWr !== 1'b1 || WB_Dst !== 5'd3 || WB_Result !== 32'hA) begin
      failures++; $display("FAIL conflict_pipe_first: got rfwr=%0b r%0d=%0h want rfwr=1 r3=a", RFWr, WB_Dst, WB_Result); end
    checks++; if (fifo_count !== 2'd1) begin failures++; $display("FAIL conflict_count: got %0d want 1", fifo_count); end
    checks++; if (ID_rt_pending !== 1'b1) begin failures++; $display("FAIL conflict_rt_pending: got %0b want 1", ID_rt_pending); end
    checks++; if (ID_rs_pending !== 1'b0) begin failures++; $display("FAIL conflict_rs_pending: got %0b want 0", ID_rs_pending); end
    tick();
    checks++; if (RFWr !== 1'b1 || WB_Dst !== 5'd7 || WB_Result !== 32'hB) begin
      failures++; $display("FAIL conflict_aux_second: got rfwr=%0b r%0d=%0h want rfwr=1 r7=b", RFWr, WB_Dst, WB_Result); end
    checks++; if (ID_rt_pending !== 1'b0) begin failures++; $display("FAIL conflict_pending_clear: got %0b want 0", ID_rt_pending); end
  endtask

  task automatic test_starvation();
    logic [4:0] exp_dst;
    logic [31:0] exp_res;
    apply_reset();
    for (int j = 0; j <= 6; j++) begin
      pipe_valid  = 1;
      pipe_dst    = (j == 6) ? 5'd15 : 5'(10 + j);
      pipe_result = 32'h100 + 32'(pipe_dst);
      aux_valid   = (j == 0); aux_dst = 5'd9; aux_result = 32'h99;
      tick();
      if (j + 1 <= 5)      exp_dst = 5'(10 + j);
      else if (j + 1 == 6) exp_dst = 5'd9;
      else                 exp_dst = 5'd15;
      exp_res = (j + 1 == 6) ? 32'h99 : 32'h100 + 32'(exp_dst);
      checks++; if (pipe_stall !== (j + 1 == 5)) begin
        failures++; $display("FAIL starve_stall_t%0d: got %0b want %0b", j + 1, pipe_stall, (j + 1 == 5)); end
      checks++; if (RFWr !== 1'b1 || WB_Dst !== exp_dst || WB_Result !== exp_res) begin
        failures++; $display("FAIL starve_write_t%0d: got rfwr=%0b r%0d=%0h want rfwr=1 r%0d=%0h",
                             j + 1, RFWr, WB_Dst, WB_Result, exp_dst, exp_res); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_full();
    int a = 0;
    bit exp_ready;
    int exp_cnt;
    apply_reset();
    pipe_valid = 1; pipe_dst = 5'd1; pipe_result = 32'h11;
    for (int k = 0; k <= 6; k++) begin
      aux_valid = 1; aux_dst = 5'(20 + a); aux_result = 32'h200 + 32'(a);
      #1;
      exp_ready = (k < 2) || (k == 6);
      exp_cnt   = (k == 0) ? 0 : (k == 1 || k == 6) ? 1 : 2;
      checks++; if (aux_ready !== exp_ready) begin
        failures++; $display("FAIL full_ready_k%0d: got %0b want %0b", k, aux_ready, exp_ready); end
      checks++; if (int'(fifo_count) != exp_cnt) begin
        failures++; $display("FAIL full_count_k%0d: got %0d want %0d", k, fifo_count, exp_cnt); end
      tick();
      if (exp_ready) a++;
    end
    idle_inputs();
    checks++; if (fifo_count !== 2'd2) begin failures++; $display("FAIL full_refill_count: got %0d want 2", fifo_count); end
    tick();
    checks++; if (RFWr !== 1'b1 || WB_Dst !== 5'd21) begin failures++; $display("FAIL full_drain1: got r%0d want r21", WB_Dst); end
    tick();
    checks++; if (RFWr !== 1'b1 || WB_Dst !== 5'd22 || WB_Result !== 32'h202) begin
      failures++; $display("FAIL full_drain2: got r%0d=%0h want r22=202", WB_Dst, WB_Result); end
    checks++; if (fifo_count !== 2'd0) begin failures++; $display("FAIL full_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_zero_dst();
    apply_reset();
    pipe_valid = 1; pipe_dst = 5'd0; pipe_result = 32'hFFFF;
    tick();
    checks++; if (RFWr !== 1'b0) begin failures++; $display("FAIL zero_pipe_rfwr: got %0b want 0", RFWr); end
    checks++; if (WB_Result !== 32'd0) begin failures++; $display("FAIL zero_pipe_hold: got %0h want 0", WB_Result); end
`ifdef DEBUG_TRACE_EN
    checks++; if (debug_wb_rf_wen !== 4'h0) begin failures++; $display("FAIL zero_debug_wen: got %0h want 0", debug_wb_rf_wen); end
`endif
    pipe_valid = 0; aux_valid = 1; aux_dst = 5'd0; aux_result = 32'hFFFF;
    tick();
    aux_valid = 0;
    checks++; if (RFWr !== 1'b0 || fifo_count !== 2'd0) begin
      failures++; $display("FAIL zero_aux: got rfwr=%0b count=%0d want rfwr=0 count=0", RFWr, fifo_count); end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    pipe_valid = 1; pipe_dst = 5'd4; pipe_result = 32'h44;
    aux_valid  = 1; aux_dst  = 5'd6; aux_result  = 32'h66;
    tick();
    pipe_dst = 5'd5; pipe_result = 32'h55; aux_dst = 5'd7; aux_result = 32'h77;
    tick();
    pipe_valid = 0; aux_valid = 0; ID_rs = 5'd6;
    #1;
    checks++; if (RFWr !== 1'b1 || fifo_count !== 2'd2 || ID_rs_pending !== 1'b1) begin
      failures++; $display("FAIL midop_setup: got rfwr=%0b count=%0d pend=%0b want 1 2 1", RFWr, fifo_count, ID_rs_pending); end
    rst = 1'b1;
    #1;
    checks++; if (RFWr !== 1'b0) begin failures++; $display("FAIL midop_rfwr: got %0b want 0", RFWr); end
    checks++; if (fifo_count !== 2'd0) begin failures++; $display("FAIL midop_count: got %0d want 0", fifo_count); end
    checks++; if (aux_ready !== 1'b0) begin failures++; $display("FAIL midop_ready: got %0b want 0", aux_ready); end
    checks++; if (ID_rs_pending !== 1'b0) begin failures++; $display("FAIL midop_pending: got %0b want 0", ID_rs_pending); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle_inputs();
    #1;
    checks++; if (aux_ready !== 1'b1) begin failures++; $display("FAIL midop_release_ready: got %0b want 1", aux_ready); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 500; n++) begin
      if (!m_stall) begin
        pipe_valid  = $urandom_range(0, 99) < 70;
        pipe_dst    = 5'($urandom_range(0, 7));
        pipe_result = $urandom;
      end
      if (!(aux_valid && !m_aux_taken)) begin
        aux_valid  = $urandom_range(0, 99) < 45;
        aux_dst    = 5'($urandom_range(0, 7));
        aux_result = $urandom;
      end
      ID_rs = 5'($urandom_range(0, 7));
      ID_rt = 5'($urandom_range(0, 7));
      #1;
      checks++; if (aux_ready !== m_ready()) begin
        failures++; $display("FAIL rand_ready_n%0d: got %0b want %0b", n, aux_ready, m_ready()); end
      checks++; if (int'(fifo_count) != mq.size()) begin
        failures++; $display("FAIL rand_count_n%0d: got %0d want %0d", n, fifo_count, mq.size()); end
      checks++; if (ID_rs_pending !== m_pending(ID_rs) || ID_rt_pending !== m_pending(ID_rt)) begin
        failures++; $display("FAIL rand_pending_n%0d: got rs=%0b rt=%0b want rs=%0b rt=%0b",
                             n, ID_rs_pending, ID_rt_pending, m_pending(ID_rs), m_pending(ID_rt)); end
      tick();
      checks++; if (RFWr !== m_rfwr || WB_Dst !== m_dst || WB_Result !== m_res) begin
        failures++; $display("FAIL rand_write_n%0d: got rfwr=%0b r%0d=%0h want rfwr=%0b r%0d=%0h",
                             n, RFWr, WB_Dst, WB_Result, m_rfwr, m_dst, m_res); end
      checks++; if (pipe_stall !== m_stall) begin
        failures++; $display("FAIL rand_stall_n%0d: got %0b want %0b", n, pipe_stall, m_stall); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_bypass();
    test_conflict();
    test_starvation();
    test_full();
    test_zero_dst();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
